demux_dispatch_ctrl: RTL and testbench
======================================

Name: demux_dispatch_ctrl

Overview:
- Sequences a 4-bit 1:4 demultiplexer datapath: accepts one valid/ready input stream and dispatches each word to one of four output channels.
- Each output channel has its own one-entry holding register and valid/ready handshake.
- Two routing modes: addressed (per-word destination) and round-robin.
- Sits between a single producer and four independent consumers; mode changes are drained safely before they apply.

Parameters:
- DATA_W, 4, width of data words.
- CNT_W, 8, width of the accepted-word counter (wraps).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts word this cycle
- in_data  in  DATA_W  input word
- in_dest  in  2  destination channel; used in addressed mode only
- mode_req  in  1  requested mode: 0 = addressed, 1 = round-robin
- out_valid  out  4  bit N set = channel N holding register full
- out_ready  in  4  bit N = consumer N takes word
- out_data0..out_data3  out  DATA_W each  channel holding registers
- cur_mode  out  1  mode currently in effect
- rr_ptr  out  2  next round-robin target
- draining  out  1  mode-change drain in progress
- accept_cnt  out  CNT_W  total accepted words, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0, all out_dataN = 0, cur_mode = 0, rr_ptr = 0, accept_cnt = 0, state RUN.
  - Reset mid-transfer discards all held words.
- Target selection:
  - tgt = in_dest when cur_mode = 0; tgt = rr_ptr when cur_mode = 1.
- Acceptance in RUN:
  - in_ready = !out_valid[tgt] | out_ready[tgt].
  - Full throughput: a word can be accepted in the same cycle the target drains.
- Accept (in_valid & in_ready):
  - On the next edge, out_data[tgt] <= in_data and out_valid[tgt] <= 1.
  - Latency is 1 cycle from acceptance to out_valid.
  - accept_cnt increments; in round-robin mode rr_ptr <= rr_ptr + 1 (3 wraps to 0).
- Drain (out_valid[N] & out_ready[N] with no new word for N): out_valid[N] <= 0 and out_data[N] <= 0.
  - Output data is zero whenever invalid.
- Hold: while out_valid[N] & !out_ready[N], out_data[N] stays stable.
- Channels drain independently; only one channel can be loaded per cycle.
- FSM, two states:
  - RUN to DRAIN when mode_req != cur_mode. The input is not accepted in the transition cycle: in_ready is forced to 0 combinationally whenever mode_req != cur_mode.
  - DRAIN: in_ready = 0 and draining = 1.
  - DRAIN to RUN when out_valid == 0. On that edge, cur_mode <= mode_req and rr_ptr <= 0.
  - If mode_req toggles back to cur_mode during DRAIN, still complete the drain, then return to RUN with cur_mode unchanged and rr_ptr reset to 0.
- Strict round-robin (macro absent): when the rr_ptr channel is full and not ready, the block stalls; it does not skip.
- in_dest is ignored in round-robin mode.

Optional Feature:
- Macro: DEMUX_DISPATCH_RR_SKIP_EN.
- When defined, in round-robin mode only:
  - tgt is the first channel, searching from rr_ptr upward with wrap, whose in_ready term (!out_valid | out_ready) holds.
  - After an accept, rr_ptr <= tgt + 1.
  - If no channel qualifies, in_ready = 0.
- When undefined, strict round-robin as described above.
- Addressed mode is identical either way.

Decomposition:
- Package demux_dispatch_pkg holds:
  - typedef enum state_t {RUN, DRAIN};
  - typedef enum mode_t {MODE_ADDR = 0, MODE_RR = 1};
  - localparam NUM_CH = 4.
- Sub-module demux_dispatch_slot: one channel's holding register, with load, data, ready, valid and data-out. Instantiated 4 times.
- The top level holds the FSM, target select, pointer and counter.

Test Plan:
- Addressed mode, out_ready = 4'hF, send 0x5 to dest 2 -> next cycle out_valid = 4'b0100, out_data2 = 0x5, then zero after drain; accept_cnt = 1.
- Addressed mode, out_ready[1] = 0, send 0xA then 0xB to dest 1 -> 0xA held stable, second word sees in_ready = 0 until out_ready[1] rises; then 0xB loads in the drain cycle with no bubble.
- Round-robin mode, all ready, send 0x1..0x6 -> channels 0,1,2,3,0,1 receive them in order; rr_ptr = 2 at the end; in_dest ignored.
- Round-robin mode, channel 1 full and not ready, rr_ptr = 1 -> in_ready = 0 when the macro is undefined; with DEMUX_DISPATCH_RR_SKIP_EN, the word goes to channel 2 and rr_ptr becomes 3.
- Channel 3 held with out_ready = 0, toggle mode_req 0->1 -> in_ready = 0 immediately, draining = 1 until out_ready[3] drains it; then cur_mode = 1, rr_ptr = 0.
- Assert rst mid-stream with out_valid = 4'b1011 -> all outputs, counters and cur_mode are 0 asynchronously; first accept after release increments accept_cnt to 1.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the 1:4 demux dispatch controller.
package demux_dispatch_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_t;

endpackage

// File: rtl/demux_dispatch_slot.sv
// One output channel: a single-entry holding register with valid/ready handshake.
// Data reads as zero whenever the slot is empty.
module demux_dispatch_slot #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
      dout  <= '0;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// 1:4 demux dispatch controller: target select, mode-change drain FSM, rr pointer, counter.
// Optional macro DEMUX_DISPATCH_RR_SKIP_EN: round-robin skips full, stalled channels.
//
//   state | meaning
//   RUN   | accepting words, cur_mode in effect
//   DRAIN | mode change pending; input blocked until all slots empty
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              mode_req,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              cur_mode,
  output logic [1:0]        rr_ptr,
  output logic              draining,
  output logic [CNT_W-1:0]  accept_cnt
);

  state_t             state_q, state_d;
  mode_t              mode_q, req_mode;
  logic [1:0]         rr_q;
  logic [1:0]         tgt;
  logic               tgt_ok;
  logic               accept;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_CH-1:0]  slot_free;
  logic [NUM_CH-1:0]  load;
  logic [DATA_W-1:0]  slot_dout [NUM_CH];

  assign req_mode  = mode_t'(mode_req);
  assign slot_free = ~out_valid | out_ready;

`ifdef DEMUX_DISPATCH_RR_SKIP_EN
  logic [1:0] idx;

  // Descending scan so the lowest offset from rr_q wins.
  always_comb begin
    idx    = '0;
    tgt    = in_dest;
    tgt_ok = slot_free[in_dest];
    if (mode_q == MODE_RR) begin
      tgt    = rr_q;
      tgt_ok = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = 2'(rr_q + 2'(i));
        if (slot_free[idx]) begin
          tgt    = idx;
          tgt_ok = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    tgt    = (mode_q == MODE_RR) ? rr_q : in_dest;
    tgt_ok = slot_free[tgt];
  end
`endif

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    draining = 1'b0;
    case (state_q)
      RUN: begin
        if (req_mode != mode_q) state_d = DRAIN;
        else                    in_ready = tgt_ok;
      end
      DRAIN: begin
        draining = 1'b1;
        if (out_valid == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign load   = NUM_CH'(accept) << tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      mode_q  <= MODE_ADDR;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // A reverted request still lands here: mode_q rewrites to itself, pointer restarts.
      if (state_q == DRAIN && state_d == RUN) begin
        mode_q <= req_mode;
        rr_q   <= '0;
      end else if (accept && mode_q == MODE_RR) begin
        rr_q <= 2'(tgt + 2'd1);
      end
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_dispatch_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .din   (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .dout  (slot_dout[g])
    );
  end

  assign out_data0  = slot_dout[0];
  assign out_data1  = slot_dout[1];
  assign out_data2  = slot_dout[2];
  assign out_data3  = slot_dout[3];
  assign cur_mode   = mode_q;
  assign rr_ptr     = rr_q;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed self-checking bench for demux_dispatch_ctrl (either build of DEMUX_DISPATCH_RR_SKIP_EN).
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic [1:0] in_dest = '0;
  logic       mode_req = 1'b0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic       cur_mode;
  logic [1:0] rr_ptr;
  logic       draining;
  logic [7:0] accept_cnt;
  logic [3:0] od [4];

  int checks = 0;
  int errors = 0;
  int base_cnt;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DATA_W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .mode_req   (mode_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .cur_mode   (cur_mode),
    .rr_ptr     (rr_ptr),
    .draining   (draining),
    .accept_cnt (accept_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_cur_mode", 32'(cur_mode), 32'h0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_accept_cnt", 32'(accept_cnt), 32'h0);
    chk("rst_data2", 32'(out_data2), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Addressed, all ready: 0x5 to channel 2
    out_ready = 4'hF; in_valid = 1'b1; in_data = 4'h5; in_dest = 2'd2;
    #1 chk("a1_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("a1_out_valid", 32'(out_valid), 32'h4);
    chk("a1_data2", 32'(out_data2), 32'h5);
    chk("a1_cnt", 32'(accept_cnt), 32'h1);
    step();
    chk("a1_drained_valid", 32'(out_valid), 32'h0);
    chk("a1_drained_data2", 32'(out_data2), 32'h0);

    // Addressed, channel 1 stalled: hold 0xA, then 0xB loads in the drain cycle
    out_ready = 4'b1101; in_valid = 1'b1; in_data = 4'hA; in_dest = 2'd1;
    step();
    chk("a2_valid_a", 32'(out_valid), 32'h2);
    chk("a2_data1_a", 32'(out_data1), 32'hA);
    in_data = 4'hB;
    #1 chk("a2_blocked", 32'(in_ready), 32'h0);
    step();
    chk("a2_hold_data1", 32'(out_data1), 32'hA);
    chk("a2_still_blocked", 32'(in_ready), 32'h0);
    out_ready = 4'hF;
    #1 chk("a2_ready_same_cycle", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("a2_valid_b", 32'(out_valid), 32'h2);
    chk("a2_data1_b", 32'(out_data1), 32'hB);
    chk("a2_cnt", 32'(accept_cnt), 32'h3);
    step();

    // Switch to round-robin with nothing held
    mode_req = 1'b1;
    #1 chk("m1_in_ready_blocked", 32'(in_ready), 32'h0);
    step();
    chk("m1_draining", 32'(draining), 32'h1);
    step();
    chk("m1_cur_mode", 32'(cur_mode), 32'h1);
    chk("m1_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("m1_not_draining", 32'(draining), 32'h0);

    // Round-robin, all ready, 0x1..0x6 with in_dest held at 3
    in_dest = 2'd3; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_data = 4'(k);
      step();
      chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'(1 << ((k - 1) % 4)));
      chk($sformatf("rr_data_%0d", k), 32'(od[(k - 1) % 4]), 32'(k));
    end
    in_valid = 1'b0;
    chk("rr_ptr_end", 32'(rr_ptr), 32'h2);
    chk("rr_cnt", 32'(accept_cnt), 32'h9);
    step();

    // Round-robin with channel 1 stalled: walk rr_ptr around to 1 with ch1 full
    out_ready = 4'b1101; in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_data = (k == 3) ? 4'hC : 4'(k + 2);
      step();
    end
    chk("sk_rr_ptr", 32'(rr_ptr), 32'h1);
    chk("sk_ch1_full", 32'(out_valid[1]), 32'h1);
    chk("sk_ch1_data", 32'(out_data1), 32'hC);
    in_data = 4'hD;
`ifdef DEMUX_DISPATCH_RR_SKIP_EN
    #1 chk("sk_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("sk_rr_after", 32'(rr_ptr), 32'h3);
    chk("sk_data2", 32'(out_data2), 32'hD);
    chk("sk_cnt", 32'(accept_cnt), 32'h11);
    base_cnt = 17;
`else
    #1 chk("sk_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("sk_rr_after", 32'(rr_ptr), 32'h1);
    chk("sk_ch1_hold", 32'(out_data1), 32'hC);
    chk("sk_cnt", 32'(accept_cnt), 32'h10);
    base_cnt = 16;
`endif
    in_valid = 1'b0; out_ready = 4'hF;
    step();
    chk("sk_all_drained", 32'(out_valid), 32'h0);

    // Back to addressed mode
    mode_req = 1'b0;
    step();
    step();
    chk("m2_cur_mode", 32'(cur_mode), 32'h0);

    // Channel 3 held, then request round-robin: drain waits on channel 3
    out_ready = 4'b0111; in_valid = 1'b1; in_data = 4'h6; in_dest = 2'd3;
    step();
    in_valid = 1'b0;
    chk("m3_held", 32'(out_valid), 32'h8);
    mode_req = 1'b1; in_valid = 1'b1; in_data = 4'h9; in_dest = 2'd0;
    #1 chk("m3_in_ready_now", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    step();
    chk("m3_draining", 32'(draining), 32'h1);
    chk("m3_mode_unchanged", 32'(cur_mode), 32'h0);
    step();
    chk("m3_still_draining", 32'(draining), 32'h1);
    chk("m3_still_held", 32'(out_data3), 32'h6);
    out_ready = 4'hF;
    step();
    chk("m3_ch3_drained", 32'(out_valid), 32'h0);
    step();
    chk("m3_cur_mode", 32'(cur_mode), 32'h1);
    chk("m3_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("m3_done", 32'(draining), 32'h0);
    chk("m3_cnt", 32'(accept_cnt), 32'(base_cnt + 1));

    // Fill all four channels with nothing ready, drain ch2 only -> 1011, then async reset
    out_ready = 4'h0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 4'(k + 1);
      step();
    end
    in_valid = 1'b0; out_ready = 4'b0100;
    step();
    out_ready = 4'h0;
    chk("r_pre_valid", 32'(out_valid), 32'hB);
    mode_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("r_out_valid", 32'(out_valid), 32'h0);
    chk("r_data0", 32'(out_data0), 32'h0);
    chk("r_cur_mode", 32'(cur_mode), 32'h0);
    chk("r_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("r_cnt", 32'(accept_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 4'hF; in_valid = 1'b1; in_data = 4'h3; in_dest = 2'd1;
    step();
    in_valid = 1'b0;
    chk("r_first_cnt", 32'(accept_cnt), 32'h1);
    chk("r_first_valid", 32'(out_valid), 32'h2);
    chk("r_first_data1", 32'(out_data1), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
